// File: rtl/load_size_unit.sv
// Load sequencer: one word read per request, then low-lane byte/halfword/word extraction.
// Optional sign extension is built only when LOAD_SIGN_EXT_EN is defined; otherwise loads zero-extend.
module load_size_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  LSizeCtrl,
  input  logic        lsigned,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic [31:0] data_out,
  output logic        done,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, FIN} state_e;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [7:0]  cnt_q;
  logic        err_q;
  logic [31:0] dout_q;
  logic [31:0] dout_d;
  logic [23:0] byte_fill;
  logic [15:0] half_fill;

`ifdef LOAD_SIGN_EXT_EN
  logic sgn_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sgn_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      sgn_q <= lsigned;
    end
  end

  assign byte_fill = {24{sgn_q & mem_data[7]}};
  assign half_fill = {16{sgn_q & mem_data[15]}};
`else
  logic unused_lsigned;
  assign unused_lsigned = lsigned;
  assign byte_fill = '0;
  assign half_fill = '0;
`endif

  // Extraction always reads the low lanes, mirroring the store merge path.
  always_comb begin
    dout_d = mem_data;
    case (size_q)
      2'b10:   dout_d = {byte_fill, mem_data[7:0]};
      2'b01:   dout_d = {half_fill, mem_data[15:0]};
      default: dout_d = mem_data;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= addr;
            size_q  <= LSizeCtrl;
            cnt_q   <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          // Ready takes priority over a timeout firing in the same cycle.
          if (mem_ready) begin
            dout_q  <= dout_d;
            err_q   <= 1'b0;
            state_q <= FIN;
          end else if (cnt_q == LAST_WAIT) begin
            dout_q  <= '0;
            err_q   <= 1'b1;
            state_q <= FIN;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd   = (state_q == REQ);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign err      = done & err_q;
  assign mem_addr = addr_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_load_size_unit.sv
// Directed bench for load_size_unit: transaction-level expected waveforms checked every cycle,
// plus literal data_out expectations at each completion.
module tb_load_size_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] addr;
  logic [1:0]  sz;
  logic        lsg;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] data_out;
  logic        done;
  logic        err;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  logic        e_rd, e_busy, e_done, e_err;
  logic [31:0] e_addr, e_dout;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  load_size_unit #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .addr      (addr),
    .LSizeCtrl (sz),
    .lsigned   (lsg),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_data  (mem_data),
    .data_out  (data_out),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_rd",   32'(mem_rd), 32'(e_rd));
      check("busy",     32'(busy),   32'(e_busy));
      check("done",     32'(done),   32'(e_done));
      check("err",      32'(err),    32'(e_err));
      check("mem_addr", mem_addr,    e_addr);
      check("data_out", data_out,    e_dout);
    end
  end

  function automatic logic [31:0] ext(input logic [31:0] d, input logic [1:0] s, input logic sg);
    logic [31:0] v;
    logic        se;
`ifdef LOAD_SIGN_EXT_EN
    se = sg;
`else
    se = sg & 1'b0;
`endif
    if (s == 2'b10) begin
      v = d % 32'd256;
      if (se && d[7]) v = v + 32'hFFFF_FF00;
    end else if (s == 2'b01) begin
      v = d % 32'd65536;
      if (se && d[15]) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle; delay >= TO means ready never arrives in time.
  task automatic do_load(input string name, input logic [31:0] a, input logic [1:0] s,
                         input logic sg, input logic [31:0] d, input int delay,
                         input bit poke, input logic [31:0] lit);
    bit          to;
    int          n;
    logic [31:0] res;
    to  = (delay >= int'(TO));
    n   = to ? int'(TO) : delay + 1;
    res = to ? 32'h0 : ext(d, s, sg);
    start = 1'b1; addr = a; sz = s; lsg = sg;
    mem_ready = 1'b1; mem_data = 32'hDEAD_BEEF;
    step();
    for (int i = 0; i < n; i++) begin
      e_rd = 1'b1; e_busy = 1'b1; e_addr = a; e_done = 1'b0; e_err = 1'b0;
      mem_ready = (i == delay);
      mem_data  = (i == delay) ? d : ~d;
      start = poke; addr = a ^ 32'h100; sz = ~s; lsg = ~sg;
      step();
    end
    start = 1'b0; mem_ready = 1'b0;
    e_rd = 1'b0; e_busy = 1'b1; e_done = 1'b1; e_err = to; e_dout = res;
    check(name, data_out, lit);
    check({name, "_err"}, 32'(err), 32'(to));
    step();
    e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
  endtask

  logic [31:0] l_bs, l_hs, l_bs2, l_hs2;

  initial begin
`ifdef LOAD_SIGN_EXT_EN
    l_bs = 32'hFFFF_FFA5; l_hs = 32'hFFFF_F0A5; l_bs2 = 32'hFFFF_FFA5; l_hs2 = 32'hFFFF_8001;
`else
    l_bs = 32'h0000_00A5; l_hs = 32'h0000_F0A5; l_bs2 = 32'h0000_00A5; l_hs2 = 32'h0000_8001;
`endif
    reset = 1'b1; start = 1'b0; addr = '0; sz = '0; lsg = 1'b0;
    mem_ready = 1'b0; mem_data = '0;
    e_rd = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_addr = '0; e_dout = '0;
    chk_en = 1'b1;
    step();
    step();
    reset = 1'b0;
    mem_ready = 1'b1;
    step();

    do_load("byte_s",   32'h0000_1000, 2'b10, 1'b1, 32'h8000_F0A5, 0, 1'b0, l_bs);
    do_load("byte_u",   32'h0000_1004, 2'b10, 1'b0, 32'h8000_F0A5, 0, 1'b0, 32'h0000_00A5);
    do_load("half_s",   32'h0000_1008, 2'b01, 1'b1, 32'h8000_F0A5, 0, 1'b0, l_hs);
    do_load("word_00",  32'h0000_100C, 2'b00, 1'b1, 32'h8000_F0A5, 0, 1'b0, 32'h8000_F0A5);
    do_load("word_11",  32'h0000_1010, 2'b11, 1'b1, 32'h8000_F0A5, 0, 1'b0, 32'h8000_F0A5);
    do_load("half_u",   32'h0000_1014, 2'b01, 1'b0, 32'h8000_F0A5, 0, 1'b0, 32'h0000_F0A5);
    do_load("byte_7f",  32'h0000_1018, 2'b10, 1'b1, 32'h0000_007F, 0, 1'b0, 32'h0000_007F);
    do_load("byte_a5",  32'h0000_101C, 2'b10, 1'b1, 32'h0000_00A5, 0, 1'b0, l_bs2);
    do_load("wait3",    32'h0000_0040, 2'b01, 1'b1, 32'h1234_8001, 3, 1'b1, l_hs2);
    do_load("timeout",  32'h0000_0050, 2'b10, 1'b1, 32'h0000_00FF, 99, 1'b0, 32'h0000_0000);
    do_load("wait1",    32'h0000_0060, 2'b00, 1'b0, 32'hCAFE_BABE, 1, 1'b0, 32'hCAFE_BABE);

    start = 1'b1; addr = 32'h0000_0080; sz = 2'b00; lsg = 1'b0; mem_ready = 1'b0;
    step();
    start = 1'b0;
    e_rd = 1'b1; e_busy = 1'b1; e_addr = 32'h0000_0080; e_done = 1'b0; e_err = 1'b0;
    step();
    #2;
    reset = 1'b1;
    e_rd = 1'b0; e_busy = 1'b0; e_addr = '0; e_dout = '0;
    #1;
    check("rst_mem_rd", 32'(mem_rd), 32'h0);
    check("rst_busy",   32'(busy),   32'h0);
    step();
    step();
    reset = 1'b0;
    step();

    do_load("post_rst", 32'h0000_0090, 2'b00, 1'b1, 32'h1357_9BDF, 0, 1'b0, 32'h1357_9BDF);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
